// File: rtl/logic_pipe_pkg.sv
// Shared constants and types for the round-robin two-stage logic pipeline.
// Modules that use a non-default operand width keep a locally sized copy of the stage record.
package logic_pipe_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 8;
  localparam int IDW_DEF   = $clog2(N_REQ_DEF);

  typedef struct packed {
    logic               valid;
    logic [W_DEF-1:0]   c;
    logic [W_DEF-1:0]   bd;
    logic [IDW_DEF-1:0] id;
  } stage_t;

  function automatic logic [1:0] stage_count(input logic v1, input logic v2);
    return {1'b0, v1} + {1'b0, v2};
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: grants the first requesting index strictly after ptr, wrapping.
module rr_select #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any
);

  // Scan from ptr+1 onward; the first hit wins and later hits are masked by 'any'.
  always_comb begin : scan
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/rr_logic_pipe_arbiter.sv
// Round-robin arbiter feeding a two-stage logic pipeline (c = a&b, d = c|b) with a global stall.
// Output valid/data come straight from the stage-2 registers.
module rr_logic_pipe_arbiter
  import logic_pipe_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0][W-1:0]   req_a,
  input  logic [N_REQ-1:0][W-1:0]   req_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_c,
  output logic [W-1:0]              out_d,
  output logic [IDW-1:0]            out_id,
  output logic [1:0]                occupancy
);

  typedef struct packed {
    logic           valid;
    logic [W-1:0]   c;
    logic [W-1:0]   bd;
    logic [IDW-1:0] id;
  } pipe_stage_t;

  pipe_stage_t    s1;
  pipe_stage_t    s2;
  logic [IDW-1:0] rr_ptr;

  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             any;
  logic             adv;
  logic             accept;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;

  rr_select #(.N(N_REQ), .IDW(IDW)) u_sel (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Global advance, handshake and operand mux for the granted requester.
  always_comb begin
    adv    = !s2.valid || out_ready;
    accept = adv && any;
    sel_a  = req_a[grant_idx];
    sel_b  = req_b[grant_idx];
    if (adv) begin
      req_ready = grant;
    end else begin
      req_ready = '0;
    end
  end

  // Pipeline stages and round-robin pointer; everything freezes while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      rr_ptr <= IDW'(N_REQ - 1);
    end else if (adv) begin
      s2.valid <= s1.valid;
      s2.c     <= s1.c;
      s2.bd    <= s1.c | s1.bd;
      s2.id    <= s1.id;
      if (accept) begin
        s1.valid <= 1'b1;
        s1.c     <= sel_a & sel_b;
        s1.bd    <= sel_b;
        s1.id    <= grant_idx;
        rr_ptr   <= grant_idx;
      end else begin
        s1.valid <= 1'b0;
      end
    end else begin
      s1     <= s1;
      s2     <= s2;
      rr_ptr <= rr_ptr;
    end
  end

  assign out_valid = s2.valid;
  assign out_c     = s2.c;
  assign out_d     = s2.bd;
  assign out_id    = s2.id;
  assign occupancy = stage_count(s1.valid, s2.valid);

endmodule

// File: tb/tb_rr_logic_pipe_arbiter.sv
// Directed self-checking bench for rr_logic_pipe_arbiter (N_REQ=4, W=8).
module tb_rr_logic_pipe_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0][W-1:0]  req_a;
  logic [N-1:0][W-1:0]  req_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_c;
  logic [W-1:0]         out_d;
  logic [1:0]           out_id;
  logic [1:0]           occupancy;

  int evals = 0;
  int fails = 0;

  rr_logic_pipe_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_id    (out_id),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_acc[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_c", 32'(out_c), 32'h0);
    check("rst_out_d", 32'(out_d), 32'h0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_rr_ptr", 32'(dut.rr_ptr), 32'd3);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;

    // Single request from requester 0
    req_valid = 4'b0001;
    req_a[0]  = 8'hF0;
    req_b[0]  = 8'h3C;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check("single_e1_valid", 32'(out_valid), 32'd0);
    check("single_e1_occ", 32'(occupancy), 32'd1);
    check("single_e1_ptr", 32'(dut.rr_ptr), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_c", 32'(out_c), 32'h30);
    check("single_d", 32'(out_d), 32'h3C);
    check("single_id", 32'(out_id), 32'd0);
    tick();
    check("single_drain_valid", 32'(out_valid), 32'd0);
    check("single_drain_occ", 32'(occupancy), 32'd0);

    // Re-reset so requester 0 has first priority again
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All requesters held valid: c = d = 0x30 + i
    for (int i = 0; i < N; i++) begin
      req_a[i] = 8'hF0 | 8'(i);
      req_b[i] = 8'h30 + 8'(i);
    end
    req_valid = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      #1;
      check($sformatf("all_ready_%0d", j), 32'(req_ready), 32'(1 << exp_acc[j]));
      tick();
      if (j >= 1) begin
        check($sformatf("all_valid_%0d", j), 32'(out_valid), 32'd1);
        check($sformatf("all_id_%0d", j), 32'(out_id), 32'(exp_acc[j-1]));
        check($sformatf("all_c_%0d", j), 32'(out_c), 32'h30 + 32'(exp_acc[j-1]));
      end else begin
        check("all_first_valid", 32'(out_valid), 32'd0);
      end
    end

    // Backpressure with full pipeline: result from req 0 stuck at output, req 1 in stage 1
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      check($sformatf("bp_ready_%0d", j), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("bp_valid_%0d", j), 32'(out_valid), 32'd1);
      check($sformatf("bp_id_%0d", j), 32'(out_id), 32'd0);
      check($sformatf("bp_c_%0d", j), 32'(out_c), 32'h30);
      check($sformatf("bp_occ_%0d", j), 32'(occupancy), 32'd2);
      check($sformatf("bp_ptr_%0d", j), 32'(dut.rr_ptr), 32'd1);
    end
    out_ready = 1'b1;
    req_valid = 4'b0000;
    tick();
    check("bp_resume_valid", 32'(out_valid), 32'd1);
    check("bp_resume_id", 32'(out_id), 32'd1);
    check("bp_resume_c", 32'(out_c), 32'h31);
    check("bp_resume_occ", 32'(occupancy), 32'd1);
    tick();
    check("bp_drain_valid", 32'(out_valid), 32'd0);

    // Back-to-back transactions must not mix: d = (a&b)|b
    req_a[2]  = 8'hFF;
    req_b[2]  = 8'h00;
    req_a[3]  = 8'h00;
    req_b[3]  = 8'h0F;
    req_valid = 4'b0100;
    #1;
    check("b2b_ready_2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1000;
    #1;
    check("b2b_ready_3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    check("b2b_first_id", 32'(out_id), 32'd2);
    check("b2b_first_c", 32'(out_c), 32'h00);
    check("b2b_first_d", 32'(out_d), 32'h00);
    tick();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_id", 32'(out_id), 32'd3);
    check("b2b_second_c", 32'(out_c), 32'h00);
    check("b2b_second_d", 32'(out_d), 32'h0F);
    tick();

    // Reset mid-flight with a full pipeline
    req_valid = 4'b0011;
    tick();
    tick();
    check("mid_occ_full", 32'(occupancy), 32'd2);
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    check("mid_rst_ptr", 32'(dut.rr_ptr), 32'd3);
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("mid_next_grant", 32'(req_ready), 32'h1);
    tick();
    check("mid_next_ptr", 32'(dut.rr_ptr), 32'd0);

    // Sparse request: only requester 2, granted every cycle
    req_valid = 4'b0100;
    for (int j = 0; j < 4; j++) begin
      #1;
      check($sformatf("sparse_ready_%0d", j), 32'(req_ready), 32'h4);
      tick();
      check($sformatf("sparse_ptr_%0d", j), 32'(dut.rr_ptr), 32'd2);
    end
    check("sparse_out_id", 32'(out_id), 32'd2);
    check("sparse_occ", 32'(occupancy), 32'd2);
    req_valid = 4'b0000;
    tick();
    tick();
    check("final_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
